seq_match_arb: RTL and testbench

Round-robin scheduler that shares one 2-bit symbol sequence detector between N_REQ requesters. Each requester streams 2-bit symbols in through a req/grant handshake. The block keeps a private detector state and a hit counter for every channel, and time-multiplexes a single next-state path between them. It sits between the symbol sources and downstream logic that needs per-channel match events and counts.

---
 rtl/seq_match_arb_pkg.sv | 20 ++
 rtl/seq_match_arb_if.sv | 17 +
 rtl/seq_match_arb_rr_arb.sv | 20 ++
 rtl/seq_match_arb.sv | 58 +++++
 tb/tb_seq_match_arb.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/seq_match_arb_pkg.sv
// seq_pkg: detector state type, symbol constants and the shared next-state function
package seq_pkg;
    typedef enum logic [1:0] {S0 = 2'b00, S1 = 2'b01, S2 = 2'b10, S3 = 2'b11} state_t;
    localparam logic [1:0] SYM_00 = 2'b00;
    localparam logic [1:0] SYM_01 = 2'b01;
    localparam logic [1:0] SYM_10 = 2'b10;
    localparam logic [1:0] SYM_11 = 2'b11;
    function automatic int id_w(int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
    function automatic state_t seq_next(state_t s, logic [1:0] y);
        case (y)
            SYM_00: return S0;
            SYM_01: return S1;
            SYM_10: return (s == S1 || s == S2) ? S2 : S0;
            SYM_11: return (s == S2 || s == S3) ? S3 : S0;
            default: return S0;
        endcase
    endfunction
endpackage

// File: rtl/seq_match_arb_if.sv
// seq_match_arb_if: requester, clear, hit and read-port signals of seq_match_arb
interface seq_match_arb_if #(parameter int N_REQ = 4, parameter int CNT_W = 8);
    import seq_pkg::*;
    localparam int ID_W = id_w(N_REQ);
    logic [N_REQ-1:0] req;
    logic [2*N_REQ-1:0] sym;
    logic [N_REQ-1:0] grant;
    logic clr;
    logic [ID_W-1:0] clr_id;
    logic hit;
    logic [ID_W-1:0] hit_id;
    logic [ID_W-1:0] rd_id;
    logic [1:0] rd_state;
    logic [CNT_W-1:0] rd_cnt;
    modport master (output req, sym, clr, clr_id, rd_id, input grant, hit, hit_id, rd_state, rd_cnt);
    modport slave (input req, sym, clr, clr_id, rd_id, output grant, hit, hit_id, rd_state, rd_cnt);
endinterface

// File: rtl/seq_match_arb_rr_arb.sv
// rr_arb: first asserted request at or after ptr, wrapping, as one-hot grant plus binary id
module rr_arb #(parameter int N = 4, parameter int ID_W = 2) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] id
);
    always_comb begin
        int j;
        grant = '0;
        id = '0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (grant == '0 && req[j]) begin
                grant[j] = 1'b1;
                id = ID_W'(j);
            end
        end
    end
endmodule

// File: rtl/seq_match_arb.sv
// seq_match_arb: round-robin sharing of one 2-bit sequence detector across N_REQ channels
// per-channel hit counters are built only when SEQ_MATCH_ARB_CNT_EN is defined
module seq_match_arb
    import seq_pkg::*;
#(parameter int N_REQ = 4, parameter int CNT_W = 8) (
    input logic clk,
    input logic reset,
    seq_match_arb_if.slave bus
);
    localparam int ID_W = id_w(N_REQ);
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] gid;
    logic [N_REQ-1:0] gnt;
    state_t st [N_REQ];
    state_t nxt;
    logic take, kill, hit_nxt, hit_q;
    logic [ID_W-1:0] hit_id_q;
    rr_arb #(.N(N_REQ), .ID_W(ID_W)) u_arb (.req(bus.req), .ptr(ptr), .grant(gnt), .id(gid));
    assign bus.grant = reset ? '0 : gnt;
    assign take = |bus.grant;
    assign nxt = seq_next(st[gid], bus.sym[{gid, 1'b0} +: 2]);
    // a clear aimed at the channel being served swallows its symbol
    assign kill = bus.clr && bus.clr_id == gid;
    assign hit_nxt = take && !kill && nxt == S3;
    assign bus.hit = hit_q;
    assign bus.hit_id = hit_id_q;
    assign bus.rd_state = st[bus.rd_id];
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
            hit_q <= 1'b0;
            hit_id_q <= '0;
            for (int i = 0; i < N_REQ; i++) st[i] <= S0;
        end else begin
            hit_q <= hit_nxt;
            hit_id_q <= gid;
            if (take) begin
                ptr <= (gid == ID_W'(N_REQ - 1)) ? '0 : gid + 1'b1;
                st[gid] <= nxt;
            end
            if (bus.clr) st[bus.clr_id] <= S0;
        end
    end
`ifdef SEQ_MATCH_ARB_CNT_EN
    logic [CNT_W-1:0] cnt [N_REQ];
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_REQ; i++) cnt[i] <= '0;
        end else begin
            if (hit_nxt && cnt[gid] != '1) cnt[gid] <= cnt[gid] + 1'b1;
            if (bus.clr) cnt[bus.clr_id] <= '0;
        end
    end
    assign bus.rd_cnt = cnt[bus.rd_id];
`else
    assign bus.rd_cnt = CNT_W'(0);
`endif
endmodule

// File: tb/tb_seq_match_arb.sv
// tb_seq_match_arb: directed vector table plus randomized traffic against a channel-level model
module tb_seq_match_arb;
    localparam int N = 4;
    localparam int CW = 3;
`ifdef SEQ_MATCH_ARB_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    typedef struct {
        logic r; logic [3:0] q; logic [7:0] s; logic c; logic [1:0] ci; logic [1:0] ri;
        logic [3:0] g; logic h; logic [1:0] hi; logic [1:0] st; int cn;
    } vec_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    seq_match_arb_if #(.N_REQ(N), .CNT_W(CW)) bus();
    seq_match_arb #(.N_REQ(N), .CNT_W(CW)) dut (.clk(clk), .reset(reset), .bus(bus));
    int errs = 0;
    int checks = 0;
    logic [3:0] g_s;
    int m_st [N];
    int m_cnt [N];
    int m_ptr, m_hit, m_hid;
    function automatic vec_t v(logic r, logic [3:0] q, logic [7:0] s, logic c, logic [1:0] ci,
                               logic [1:0] ri, logic [3:0] g, logic h, logic [1:0] hi, logic [1:0] st, int cn);
        vec_t t;
        t.r = r; t.q = q; t.s = s; t.c = c; t.ci = ci; t.ri = ri;
        t.g = g; t.h = h; t.hi = hi; t.st = st; t.cn = cn;
        return t;
    endfunction
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask
    task automatic apply(input logic r, input logic [3:0] q, input logic [7:0] s, input logic c,
                         input logic [1:0] ci, input logic [1:0] ri);
        reset = r; bus.req = q; bus.sym = s; bus.clr = c; bus.clr_id = ci; bus.rd_id = ri;
        #1 g_s = bus.grant;
        @(posedge clk);
        #1;
    endtask
    // detector rules: 01 -> S1; 10 keeps S1/S2 in S2; 11 keeps S2/S3 in S3; anything else -> S0
    function automatic int mnext(int s, int y);
        if (y == 1) return 1;
        if (y == 2) return (s == 1 || s == 2) ? 2 : 0;
        if (y == 3) return (s >= 2) ? 3 : 0;
        return 0;
    endfunction
    function automatic int mgrant(logic [3:0] q);
        for (int k = 0; k < N; k++) if (q[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction
    task automatic mstep(input logic r, input logic [3:0] q, input logic [7:0] s, input logic c, input logic [1:0] ci);
        int gi, ns;
        if (r) begin
            for (int i = 0; i < N; i++) begin
                m_st[i] = 0;
                m_cnt[i] = 0;
            end
            m_ptr = 0; m_hit = 0; m_hid = 0;
        end else begin
            gi = mgrant(q);
            m_hit = 0;
            if (gi >= 0) begin
                ns = mnext(m_st[gi], int'(s >> (2 * gi)) & 3);
                m_ptr = (gi + 1) % N;
                if (!(c && int'(ci) == gi)) begin
                    m_st[gi] = ns;
                    if (ns == 3) begin
                        m_hit = 1;
                        m_hid = gi;
                        if (m_cnt[gi] < (1 << CW) - 1) m_cnt[gi]++;
                    end
                end
            end
            if (c) begin
                m_st[ci] = 0;
                m_cnt[ci] = 0;
            end
        end
    endtask
    initial begin
        vec_t tv[$];
        logic [3:0] q, gp, gexp;
        logic [7:0] s;
        logic r, c;
        logic [1:0] ci, ri;
        int gi;
        bus.req = '0; bus.sym = '0; bus.clr = 1'b0; bus.clr_id = '0; bus.rd_id = '0;
        tv.push_back(v(1, 4'b0000, 8'h00, 0, 0, 0, 4'b0000, 0, 0, 0, 0));
        tv.push_back(v(0, 4'b0001, 8'h01, 0, 0, 0, 4'b0001, 0, 0, 1, 0));
        tv.push_back(v(0, 4'b0001, 8'h02, 0, 0, 0, 4'b0001, 0, 0, 2, 0));
        tv.push_back(v(0, 4'b0001, 8'h03, 0, 0, 0, 4'b0001, 1, 0, 3, 1));
        tv.push_back(v(0, 4'b0000, 8'h00, 0, 0, 0, 4'b0000, 0, 0, 3, 1));
        tv.push_back(v(1, 4'b1111, 8'h55, 0, 0, 0, 4'b0000, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++) tv.push_back(v(0, 4'b1111, 8'h55, 0, 0, 2'(i), 4'b0001 << i, 0, 0, 1, 0));
        for (int i = 0; i < 4; i++) tv.push_back(v(0, 4'b1111, 8'hAA, 0, 0, 2'(i), 4'b0001 << i, 0, 0, 2, 0));
        for (int i = 0; i < 4; i++) tv.push_back(v(0, 4'b1111, 8'hFF, 0, 0, 2'(i), 4'b0001 << i, 1, 2'(i), 3, 1));
        for (int k = 1; k <= 8; k++) tv.push_back(v(0, 4'b0100, 8'hFF, 0, 0, 2, 4'b0100, 1, 2, 3, (1 + k > 7) ? 7 : 1 + k));
        tv.push_back(v(0, 4'b0010, 8'h04, 0, 0, 1, 4'b0010, 0, 0, 1, 1));
        tv.push_back(v(0, 4'b0010, 8'h08, 0, 0, 1, 4'b0010, 0, 0, 2, 1));
        tv.push_back(v(0, 4'b0010, 8'h0C, 1, 1, 1, 4'b0010, 0, 0, 0, 0));
        tv.push_back(v(0, 4'b1111, 8'h00, 0, 0, 2, 4'b0100, 0, 0, 0, 7));
        tv.push_back(v(0, 4'b1111, 8'hFF, 1, 2, 3, 4'b1000, 1, 3, 3, 2));
        tv.push_back(v(0, 4'b0000, 8'h00, 0, 0, 2, 4'b0000, 0, 0, 0, 0));
        foreach (tv[n]) begin
            apply(tv[n].r, tv[n].q, tv[n].s, tv[n].c, tv[n].ci, tv[n].ri);
            chk($sformatf("vec%0d grant", n), 32'(g_s), 32'(tv[n].g));
            chk($sformatf("vec%0d hit", n), 32'(bus.hit), 32'(tv[n].h));
            if (tv[n].h || tv[n].r) chk($sformatf("vec%0d hit_id", n), 32'(bus.hit_id), 32'(tv[n].hi));
            chk($sformatf("vec%0d rd_state", n), 32'(bus.rd_state), 32'(tv[n].st));
            chk($sformatf("vec%0d rd_cnt", n), 32'(bus.rd_cnt), CNT_EN ? tv[n].cn : 0);
        end
        q = '0; gp = '0; s = '0;
        apply(1'b1, q, s, 1'b0, 2'd0, 2'd0);
        mstep(1'b1, q, s, 1'b0, 2'd0);
        for (int n = 0; n < 1500; n++) begin
            r = $urandom_range(63) == 0;
            // a pending request keeps its symbol until granted, occasionally withdrawn
            for (int i = 0; i < N; i++) begin
                if (!(q[i] && !gp[i] && $urandom_range(7) != 0)) begin
                    q[i] = 1'($urandom_range(1));
                    s[2*i +: 2] = 2'($urandom_range(3));
                end
            end
            c = $urandom_range(7) == 0;
            ci = 2'($urandom_range(3));
            ri = 2'($urandom_range(3));
            gi = mgrant(q);
            gexp = (r || gi < 0) ? 4'b0000 : 4'b0001 << gi;
            apply(r, q, s, c, ci, ri);
            gp = g_s;
            mstep(r, q, s, c, ci);
            chk("rnd grant", 32'(g_s), 32'(gexp));
            chk("rnd hit", 32'(bus.hit), m_hit);
            if (m_hit != 0) chk("rnd hit_id", 32'(bus.hit_id), m_hid);
            chk("rnd rd_state", 32'(bus.rd_state), m_st[ri]);
            chk("rnd rd_cnt", 32'(bus.rd_cnt), CNT_EN ? m_cnt[ri] : 0);
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
